// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: op encodings,
// per-transaction control bits and pipeline-mask helpers.
package shifter_pkg;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  // Control travelling with each transaction; fill is the SRA sign captured at input.
  typedef struct packed {
    logic [2:0] op;
    logic       fill;
  } ctrl_t;

  function automatic logic [31:0] pipe_mask(input int sdepth, input logic [31:0] reg_mask);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < sdepth) m[i] = reg_mask[i];
    end
    m[sdepth-1] = 1'b1;
    return m;
  endfunction

  function automatic int pipe_latency(input int sdepth, input logic [31:0] reg_mask);
    logic [31:0] m;
    int n;
    m = pipe_mask(sdepth, reg_mask);
    n = 0;
    for (int i = 0; i < 32; i++) begin
      if (m[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/pipelined_barrel_shifter_layer.sv
// One combinational shift layer: shifts/rotates by STEP when enabled.
module shift_layer
  import shifter_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int STEP   = 1
) (
  input  logic [DWIDTH-1:0] data_i,
  input  ctrl_t             ctrl_i,
  input  logic              en_i,
  output logic [DWIDTH-1:0] data_o
);

  always_comb begin
    data_o = data_i;
    if (en_i) begin
      case (ctrl_i.op)
        OP_SLL:  data_o = {data_i[DWIDTH-STEP-1:0], {STEP{1'b0}}};
        OP_SRL:  data_o = {{STEP{1'b0}}, data_i[DWIDTH-1:STEP]};
        OP_SRA:  data_o = {{STEP{ctrl_i.fill}}, data_i[DWIDTH-1:STEP]};
        OP_ROL:  data_o = {data_i[DWIDTH-STEP-1:0], data_i[DWIDTH-1:DWIDTH-STEP]};
        OP_ROR:  data_o = {data_i[STEP-1:0], data_i[DWIDTH-1:STEP]};
        default: data_o = data_i;
      endcase
    end
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Log-depth shifter/rotator with optional pipeline registers between layers
// and valid/ready handshaking with full backpressure.
module pipelined_barrel_shifter
  import shifter_pkg::*;
#(
  parameter int          DWIDTH   = 32,
  parameter logic [31:0] REG_MASK = 32'd1 << ($clog2(DWIDTH) - 1),
  parameter int          TAG_W    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2:0]                in_op,
  input  logic [$clog2(DWIDTH)-1:0] in_shamt,
  input  logic [DWIDTH-1:0]         in_data,
  input  logic [TAG_W-1:0]          in_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DWIDTH-1:0]         out_data,
  output logic [TAG_W-1:0]          out_tag
);

  localparam int          SDEPTH = $clog2(DWIDTH);
  localparam logic [31:0] MASK   = pipe_mask(SDEPTH, REG_MASK);

  if (DWIDTH < 2 || (DWIDTH & (DWIDTH - 1)) != 0) begin : g_bad_width
    $error("pipelined_barrel_shifter: DWIDTH must be a power of two and at least 2");
  end

  typedef struct packed {
    logic [DWIDTH-1:0] data;
    logic [SDEPTH-1:0] shamt;
    ctrl_t             ctrl;
    logic [TAG_W-1:0]  tag;
  } pay_t;

  pay_t pay_in;
  assign pay_in = '{data: in_data, shamt: in_shamt,
                    ctrl: '{op: in_op, fill: in_data[DWIDTH-1]}, tag: in_tag};

  for (genvar gi = 0; gi < SDEPTH; gi++) begin : g_layer
    pay_t              pin, lay, pout;
    logic              vin, vout, rin, rout;
    logic [DWIDTH-1:0] lay_data;

    if (gi == 0) begin : g_head
      assign pin = pay_in;
      assign vin = in_valid;
    end else begin : g_link
      assign pin = g_layer[gi-1].pout;
      assign vin = g_layer[gi-1].vout;
    end

    if (gi == SDEPTH - 1) begin : g_tail
      assign rout = out_ready;
    end else begin : g_next
      assign rout = g_layer[gi+1].rin;
    end

    shift_layer #(
      .DWIDTH(DWIDTH),
      .STEP  (2 ** gi)
    ) u_layer (
      .data_i(pin.data),
      .ctrl_i(pin.ctrl),
      .en_i  (pin.shamt[gi]),
      .data_o(lay_data)
    );

    always_comb begin
      lay      = pin;
      lay.data = lay_data;
    end

    if (MASK[gi]) begin : g_reg
      logic vld_q, vld_d;
      pay_t pay_q, pay_d;

      // Payload only moves with a valid transaction so a stalled or idle
      // output keeps its last value.
      always_comb begin
        vld_d = vld_q;
        pay_d = pay_q;
        if (flush) begin
          vld_d = 1'b0;
        end else if (rin) begin
          vld_d = vin;
          if (vin) pay_d = lay;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q <= 1'b0;
          pay_q <= '0;
        end else begin
          vld_q <= vld_d;
          pay_q <= pay_d;
        end
      end

      assign rin  = !vld_q || rout;
      assign vout = vld_q;
      assign pout = pay_q;
    end else begin : g_pass
      assign rin  = rout;
      assign vout = vin;
      assign pout = lay;
    end
  end

  assign in_ready  = g_layer[0].rin;
  assign out_valid = g_layer[SDEPTH-1].vout;
  assign out_data  = g_layer[SDEPTH-1].pout.data;
  assign out_tag   = g_layer[SDEPTH-1].pout.tag;

  logic unused_tail;
  assign unused_tail = ^{g_layer[SDEPTH-1].pout.shamt, g_layer[SDEPTH-1].pout.ctrl};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench: an 8-bit default-mask instance and a 32-bit three-register instance.
module tb_pipelined_barrel_shifter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, flush;

  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [2:0] a_op, a_shamt;
  logic [7:0] a_data, a_out_data;
  logic [3:0] a_tag, a_out_tag;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [2:0]  b_op;
  logic [4:0]  b_shamt;
  logic [31:0] b_data, b_out_data;
  logic [3:0]  b_tag, b_out_tag;

  pipelined_barrel_shifter #(.DWIDTH(8), .TAG_W(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_op(a_op), .in_shamt(a_shamt),
    .in_data(a_data), .in_tag(a_tag),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_tag(a_out_tag)
  );

  pipelined_barrel_shifter #(.DWIDTH(32), .REG_MASK(32'b10101), .TAG_W(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_op(b_op), .in_shamt(b_shamt),
    .in_data(b_data), .in_tag(b_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_tag(b_out_tag)
  );

  typedef struct {
    logic [31:0] data;
    logic [3:0]  tag;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   pop_cyc_b[$];
  int   acc_cyc_b[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   acc_cyc_a = 0;
  int   pop_cyc_a = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] golden(input int w, input logic [2:0] op, input int sh,
                                         input logic [31:0] d);
    logic [63:0] m, x, r;
    m = (64'd1 << w) - 64'd1;
    x = {32'd0, d} & m;
    case (op)
      3'd0: r = (x << sh) & m;
      3'd1: r = x >> sh;
      3'd2: begin
        r = x >> sh;
        if (x[w-1]) r = r | (m & ~(m >> sh));
      end
      3'd3: r = ((x << sh) | (x >> (w - sh))) & m;
      3'd4: r = ((x >> sh) | (x << (w - sh))) & m;
      default: r = x;
    endcase
    return r[31:0];
  endfunction

  // Output monitors: pop on a completed output handshake.
  always @(negedge clk) begin
    if (rst_n && !flush && a_out_valid && a_out_ready) begin
      checks++;
      assert (qa.size() > 0) else begin
        errors++;
        $error("FAIL a_unexpected: got data %h tag %h expected no output", a_out_data, a_out_tag);
      end
      if (qa.size() > 0) begin
        exp_t e;
        e = qa.pop_front();
        check("a_data", {24'd0, a_out_data}, e.data);
        check("a_tag", {28'd0, a_out_tag}, {28'd0, e.tag});
        pop_cyc_a = cyc;
        $display("A out: data=%h tag=%h cyc=%0d", a_out_data, a_out_tag, cyc);
      end
    end
    if (rst_n && !flush && b_out_valid && b_out_ready) begin
      checks++;
      assert (qb.size() > 0) else begin
        errors++;
        $error("FAIL b_unexpected: got data %h tag %h expected no output", b_out_data, b_out_tag);
      end
      if (qb.size() > 0) begin
        exp_t e;
        e = qb.pop_front();
        check("b_data", b_out_data, e.data);
        check("b_tag", {28'd0, b_out_tag}, {28'd0, e.tag});
        pop_cyc_b.push_back(cyc);
        $display("B out: data=%h tag=%h cyc=%0d", b_out_data, b_out_tag, cyc);
      end
    end
  end

  task automatic send_a(input logic [2:0] op, input logic [2:0] sh, input logic [7:0] d,
                        input logic [3:0] tag, input logic [7:0] exp);
    logic ok;
    ok = 1'b0;
    a_in_valid = 1'b1; a_op = op; a_shamt = sh; a_data = d; a_tag = tag;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = a_in_ready && !flush;
    end
    checks++;
    assert (ok) else begin errors++; $error("FAIL a_accept: got in_ready %b expected 1", a_in_ready); end
    if (ok) begin
      qa.push_back('{data: {24'd0, exp}, tag: tag});
      acc_cyc_a = cyc;
    end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [2:0] op, input logic [4:0] sh, input logic [31:0] d,
                        input logic [3:0] tag);
    logic ok;
    ok = 1'b0;
    b_in_valid = 1'b1; b_op = op; b_shamt = sh; b_data = d; b_tag = tag;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = b_in_ready && !flush;
    end
    checks++;
    assert (ok) else begin errors++; $error("FAIL b_accept: got in_ready %b expected 1", b_in_ready); end
    if (ok) begin
      qb.push_back('{data: golden(32, op, int'(sh), d), tag: tag});
      acc_cyc_b.push_back(cyc);
    end
    @(posedge clk); #1;
    b_in_valid = 1'b0;
  endtask

  task automatic drain(input logic use_b);
    for (int n = 0; n < 200 && (use_b ? qb.size() : qa.size()) != 0; n++) @(negedge clk);
    check(use_b ? "b_drain" : "a_drain", use_b ? qb.size() : qa.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    a_in_valid = 1'b0; a_op = '0; a_shamt = '0; a_data = '0; a_tag = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_op = '0; b_shamt = '0; b_data = '0; b_tag = '0; b_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    check("rst_a_out_valid", {31'd0, a_out_valid}, 32'd0);
    check("rst_a_out_data", {24'd0, a_out_data}, 32'd0);
    check("rst_a_out_tag", {28'd0, a_out_tag}, 32'd0);
    check("rst_a_in_ready", {31'd0, a_in_ready}, 32'd1);
    check("rst_b_out_valid", {31'd0, b_out_valid}, 32'd0);
    check("rst_b_in_ready", {31'd0, b_in_ready}, 32'd1);

    // 8-bit directed vectors, default mask (one cycle latency).
    send_a(3'b010, 3'd3, 8'h96, 4'h5, 8'hF2);
    drain(1'b0);
    check("a_latency", pop_cyc_a - acc_cyc_a, 32'd1);
    send_a(3'b011, 3'd1, 8'h81, 4'h1, 8'h03);
    send_a(3'b100, 3'd7, 8'h81, 4'h2, 8'h03);
    send_a(3'b000, 3'd7, 8'hFF, 4'h3, 8'h80);
    send_a(3'b001, 3'd0, 8'h80, 4'h4, 8'h80);
    send_a(3'b111, 3'd3, 8'h5A, 4'hE, 8'h5A);
    send_a(3'b010, 3'd7, 8'h7F, 4'hF, 8'h00);
    drain(1'b0);

    // 32-bit back-to-back random stream, three register stages.
    pop_cyc_b.delete(); acc_cyc_b.delete();
    for (int i = 0; i < 16; i++)
      send_b(3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), $urandom, 4'(i));
    drain(1'b1);
    check("b_stream_count", pop_cyc_b.size(), 32'd16);
    if (pop_cyc_b.size() == 16 && acc_cyc_b.size() == 16) begin
      check("b_latency", pop_cyc_b[0] - acc_cyc_b[0], 32'd3);
      check("b_stream_span", pop_cyc_b[15] - pop_cyc_b[0], 32'd15);
    end

    // Stall: pipeline fills with three, output held stable.
    b_out_ready = 1'b0;
    send_b(3'b000, 5'd4, 32'h1234_5678, 4'h1);
    send_b(3'b010, 5'd31, 32'h8000_0000, 4'h2);
    send_b(3'b100, 5'd8, 32'hDEAD_BEEF, 4'h3);
    b_in_valid = 1'b1; b_op = 3'b011; b_shamt = 5'd16; b_data = 32'hCAFE_F00D; b_tag = 4'h4;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", {31'd0, b_in_ready}, 32'd0);
      check("stall_out_valid", {31'd0, b_out_valid}, 32'd1);
      check("stall_out_data", b_out_data, qb[0].data);
    end
    @(posedge clk); #1;
    b_out_ready = 1'b1;
    send_b(3'b011, 5'd16, 32'hCAFE_F00D, 4'h4);
    send_b(3'b001, 5'd1, 32'hFFFF_FFFF, 4'h5);
    send_b(3'b101, 5'd9, 32'h0BAD_CAFE, 4'h6);
    drain(1'b1);

    // Flush with three in flight and a simultaneous input.
    send_b(3'b000, 5'd1, 32'h0000_0001, 4'h7);
    send_b(3'b000, 5'd2, 32'h0000_0001, 4'h8);
    send_b(3'b000, 5'd3, 32'h0000_0001, 4'h9);
    b_in_valid = 1'b1; b_op = 3'b001; b_shamt = 5'd1; b_data = 32'h2; b_tag = 4'hA;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; b_in_valid = 1'b0;
    qb.delete();
    @(negedge clk);
    check("flush_out_valid", {31'd0, b_out_valid}, 32'd0);
    check("flush_in_ready", {31'd0, b_in_ready}, 32'd1);
    repeat (6) @(negedge clk);
    @(posedge clk); #1;

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 4; i++) send_b(3'b100, 5'(i + 1), 32'hA5A5_0F0F, 4'(i));
    check("pre_reset_out_valid", {31'd0, b_out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", {31'd0, b_out_valid}, 32'd0);
    qb.delete();
    @(posedge clk); #3 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, b_in_ready}, 32'd1);
    check("post_rst_out_valid", {31'd0, b_out_valid}, 32'd0);
    @(posedge clk); #1;
    pop_cyc_b.delete(); acc_cyc_b.delete();
    send_b(3'b010, 5'd4, 32'hF000_0000, 4'hC);
    drain(1'b1);
    if (pop_cyc_b.size() == 1 && acc_cyc_b.size() == 1)
      check("post_rst_latency", pop_cyc_b[0] - acc_cyc_b[0], 32'd3);
    else
      check("post_rst_count", pop_cyc_b.size(), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
